// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak message padder: FSM states and the final pad byte.
package keccak_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } pad_state_e;

  localparam logic [7:0] PAD_FINAL = 8'h80;

endpackage

// File: rtl/keccak_padder_if.sv
// Word-input / block-output stream bundle for keccak_padder.
interface keccak_padder_if #(
  parameter int unsigned W_BYTES    = 4,
  parameter int unsigned RATE_WORDS = 18
);
  localparam int unsigned BW = $clog2(W_BYTES);

  logic [W_BYTES*8-1:0]            in_data;
  logic                            in_valid;
  logic                            in_last;
  logic [BW-1:0]                   in_bytes;
  logic                            in_ready;
  logic [RATE_WORDS*W_BYTES*8-1:0] out_block;
  logic                            out_valid;
  logic                            out_last;
  logic                            out_ready;

  modport master (
    output in_data, in_valid, in_last, in_bytes, out_ready,
    input  in_ready, out_block, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, in_bytes, out_ready,
    output in_ready, out_block, out_valid, out_last
  );
endinterface

// File: rtl/keccak_pad_word.sv
// Builds the final message word: valid bytes, then the domain byte, then zeros.
module keccak_pad_word #(
  parameter int unsigned W_BYTES = 4,
  parameter logic [7:0]  DOMAIN  = 8'h06
) (
  input  logic [W_BYTES*8-1:0]       in_data,
  input  logic [$clog2(W_BYTES)-1:0] in_bytes,
  output logic [W_BYTES*8-1:0]       pad_data
);

  always_comb begin
    pad_data = '0;
    // byte 0 sits in the MSBs
    for (int unsigned b = 0; b < W_BYTES; b++) begin
      if (b < 32'(in_bytes))
        pad_data[(W_BYTES-1-b)*8 +: 8] = in_data[(W_BYTES-1-b)*8 +: 8];
      else if (b == 32'(in_bytes))
        pad_data[(W_BYTES-1-b)*8 +: 8] = DOMAIN;
    end
  end

endmodule

// File: rtl/keccak_padder.sv
// Collects message words into a rate-sized block and applies Keccak pad10*1 padding.
module keccak_padder
  import keccak_pkg::*;
#(
  parameter int unsigned W_BYTES    = 4,
  parameter int unsigned RATE_WORDS = 18,
  parameter logic [7:0]  DOMAIN     = 8'h06
) (
  input logic              clk,
  input logic              rst_n,
  keccak_padder_if.slave   bus
);

  localparam int unsigned WW    = W_BYTES * 8;
  localparam int unsigned IDX_W = $clog2(RATE_WORDS);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(RATE_WORDS - 1);

  pad_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic [WW-1:0]    blk_q [RATE_WORDS];

  logic             wr_en;
  logic [WW-1:0]    wr_data;
  logic             clr;
  logic             accept;
  logic [WW-1:0]    pad_data;

  keccak_pad_word #(
    .W_BYTES (W_BYTES),
    .DOMAIN  (DOMAIN)
  ) u_pad_word (
    .in_data  (bus.in_data),
    .in_bytes (bus.in_bytes),
    .pad_data (pad_data)
  );

  assign accept = bus.in_valid && (state_q == FILL);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    wr_en        = 1'b0;
    wr_data      = '0;
    clr          = 1'b0;
    bus.in_ready = 1'b0;
    case (state_q)
      FILL: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          wr_en   = 1'b1;
          wr_data = bus.in_last ? pad_data : bus.in_data;
          if (idx_q == IDX_MAX) begin
            state_d = FULL;
            last_d  = bus.in_last;
          end else begin
            // idx moves past the last-word slot so PAD zeroes from there on
            idx_d = idx_q + 1'b1;
            if (bus.in_last)
              state_d = PAD;
          end
        end
      end
      PAD: begin
        wr_en = 1'b1;
        if (idx_q == IDX_MAX) begin
          state_d = FULL;
          last_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          state_d = FILL;
          idx_d   = '0;
          last_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      last_q  <= 1'b0;
      blk_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      if (clr)
        blk_q <= '{default: '0};
      else if (wr_en)
        blk_q[idx_q] <= wr_data;
    end
  end

  always_comb begin
    bus.out_block = '0;
    for (int unsigned i = 0; i < RATE_WORDS; i++)
      bus.out_block[(RATE_WORDS-1-i)*WW +: WW] = blk_q[i];
    // final pad bit merges into whatever occupies the last byte, DOMAIN included
    if (last_q)
      bus.out_block[7:0] = blk_q[RATE_WORDS-1][7:0] | PAD_FINAL;
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_last  = last_q;

endmodule

// File: doc/keccak_padder.md
KECCAK_PADDER -- requirements
Module: keccak_padder

Interface
REQ-001 Parameter W_BYTES, default 4, bytes per input word; legal values 4 and 8.
REQ-002 Parameter RATE_WORDS, default 18, words per output block; rate in bits = RATE_WORDS*W_BYTES*8; legal range 2..64.
REQ-003 Parameter DOMAIN, default 8'h06, domain-separation byte (8'h06 SHA-3, 8'h1F SHAKE); bit 7 is 0.
REQ-004 clk  input  1  single clock; all state is updated on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  W_BYTES*8  message word; the first message byte is in the MSBs.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_last  input  1  in_data is the final word of the message.
REQ-009 in_bytes  input  clog2(W_BYTES)  valid bytes in the last word (0..W_BYTES-1); ignored when in_last=0.
REQ-010 in_ready  output  1  block accepts a word this cycle.
REQ-011 out_block  output  RATE_WORDS*W_BYTES*8  padded block; word 0 is in the MSBs.
REQ-012 out_valid  output  1  out_block holds a complete block.
REQ-013 out_last  output  1  the block is the final block of the message; qualified by out_valid.
REQ-014 out_ready  input  1  the consumer takes the block this cycle.

Function
REQ-015 A word transfers when in_valid=1 and in_ready=1; in_valid while in_ready=0 has no effect.
REQ-016 A non-last word is a full word; a message ending on a word boundary ends with in_last=1 and in_bytes=0.
REQ-017 States: FILL, PAD, FULL; in_ready=1 only in FILL.
REQ-018 FILL: each accepted word is written to buffer slot idx and idx increments.
REQ-019 FILL, accepted non-last word at idx=RATE_WORDS-1: go to FULL with out_last=0.
REQ-020 FILL, accepted last word: slot idx gets the padded word (REQ-021).
  - If idx=RATE_WORDS-1: go to FULL with out_last=1.
  - Otherwise: go to PAD.
REQ-021 Padded word layout:
  - in_bytes leading bytes taken from in_data;
  - the next byte is DOMAIN;
  - the remaining bytes are zero.
REQ-022 PAD: writes one all-zero word per cycle to the slots idx+1..RATE_WORDS-1, then goes to FULL with out_last=1.
  - When the last-word slot is RATE_WORDS-2, PAD lasts 1 cycle.
REQ-023 Final block, last byte of the block: bitwise OR with 8'h80.
  - If DOMAIN occupies that byte, the byte is DOMAIN|8'h80 (8'h86 for SHA-3).
  - No extra block is ever produced, because at least one free byte always exists.
REQ-024 FULL: out_valid=1; out_block and out_last are held stable until out_ready=1.
REQ-025 FULL with out_ready=1: go to FILL with idx=0; out_valid=0 on the next cycle.
  - Input is not accepted in the same cycle.
REQ-026 Latency:
  - Non-final block: out_valid rises 1 cycle after the RATE_WORDS-th word is accepted.
  - Final block: out_valid rises 1 cycle after the PAD state ends.
REQ-027 The buffer is cleared when FULL exits, so no data from an earlier message appears in a later block.
REQ-028 idx width is clog2(RATE_WORDS); idx never exceeds RATE_WORDS-1.

Reset
REQ-029 rst_n=0 immediately forces the following:
  - state=FILL, idx=0, buffer=0;
  - out_valid=0, out_last=0, out_block=0;
  - in_ready=1 (it remains 1 after rst_n is released).
REQ-030 Reset during PAD or FULL discards the partial block; no block is emitted for that message.

Structure
REQ-031 The shared package keccak_pkg holds the state enum (FILL, PAD, FULL) and the constant PAD_FINAL=8'h80.
REQ-032 One combinational sub-module keccak_pad_word (parameters W_BYTES and DOMAIN) SHALL implement REQ-021.

Verification (W_BYTES=4, RATE_WORDS=18, DOMAIN=8'h06)
REQ-033 Empty message: last word with in_bytes=0 -> out_block contains:
  - word0=32'h06000000;
  - words 1..16 = 0;
  - word17=32'h00000080;
  - out_last=1.
REQ-034 "abc": in_data=32'h61626300, in_bytes=3, in_last=1 -> word0=32'h61626306, word17=32'h00000080.
REQ-035 17 full words, then a last word 32'hAABBCC00 with in_bytes=3 -> no PAD cycle, word17=32'hAABBCC86, out_last=1.
REQ-036 18 full words, then a last word with in_bytes=0 -> two blocks:
  - first block: out_last=0;
  - second block: word0=32'h06000000, word17=32'h00000080, out_last=1.
REQ-037 Backpressure: out_ready=0 for 5 cycles in FULL while in_valid=1 -> out_block stable, in_ready=0, no word consumed.
REQ-038 Reset mid-PAD: rst_n=0 for 1 cycle -> out_valid=0, in_ready=1, and the next message produces a correctly padded block.
